pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipe. Drives PC_Wr, ID_Wr/ID_Flush of the ID stage register, and EXE/MEM/WB write/flush.
//  Sources: load-use hazards against ID_rs/ID_rt/ID_rsrtRead, multicycle MUL/DIV occupancy, I/D cache stalls, exception redirect.
//  Holds an FSM plus an MDU latency timer, so freeze windows span cycles.
// PARAMETERS
//  MUL_LAT  2   MUL/MULT cycles in EXE (1 = no stall)
//  DIV_LAT  33  DIV/DIVU cycles in EXE (>=1)
//  CNT_W    6   timer width; must satisfy 2**CNT_W > max(MUL_LAT,DIV_LAT)
// PORTS
//  clk              in   1   core clock
//  resetn           in   1   async active-low reset
//  ID_rs, ID_rt     in   5   source regs of the instr in ID
//  ID_rsrtRead      in   2   [1]=rs read, [0]=rt read
//  EXE_Dst          in   5   dest reg of the instr in EXE
//  EXE_MemRead      in   1   instr in EXE is a load
//  EXE_MulDivStart  in   1   MUL/DIV in EXE, first cycle
//  EXE_IsDiv        in   1   qualifies start: 1=div, 0=mul
//  EXE_BranchTaken  in   1   branch/jump resolved taken in EXE
//  I_Stall, D_Stall in   1   cache miss in progress
//  MEM_ExcValid     in   1   exception committed in MEM
//  PC_Wr            out  1   PC register enable
//  PC_SelExc        out  1   PC loads exception vector this cycle
//  ID_Wr, ID_Flush  out  1   ID stage register enable/clear
//  EXE_Wr, EXE_Flush out 1   EXE stage register enable/clear
//  MEM_Wr, MEM_Flush out 1   MEM stage register enable/clear
//  WB_Wr            out  1   WB stage register enable
//  MDU_Cancel       out  1   abort in-flight MUL/DIV
// BEHAVIOUR
//  Async reset: state=RUN, timer=0, exc pending=0. While resetn low: all *_Wr=0, all *_Flush=1, PC_SelExc=0, MDU_Cancel=0.
//  Outputs are combinational from registered state and inputs. State updates on posedge clk.
//  States: RUN; MDU (timer>0, EXE busy); EXC_PEND (redirect waiting for caches).
//  Priority per cycle, highest first: exception > cache freeze > MDU > load-use > branch.
//  Exception: MEM_ExcValid=1 -> ID/EXE/MEM_Flush=1, WB_Wr=0, MDU_Cancel=1, timer:=0.
//   If I_Stall|D_Stall=0, PC_Wr=PC_SelExc=1 in the same cycle and next state is RUN.
//   Otherwise next state is EXC_PEND with PC_Wr=0.
//  EXC_PEND: flushes stay asserted and PC_Wr=0 until both stalls are low.
//   Then PC_Wr=PC_SelExc=1 for exactly one cycle and the state returns to RUN.
//  Cache freeze (I_Stall|D_Stall): every *_Wr=0 and no flush. The MDU timer keeps decrementing. State is unchanged.
//  MDU: in RUN with EXE_MulDivStart=1, timer:=(EXE_IsDiv?DIV_LAT:MUL_LAT)-1.
//   If the loaded value is nonzero, enter MDU.
//   In MDU: PC/ID/EXE_Wr=0, MEM_Flush=1 (bubble), WB_Wr=1.
//   Timer decrements each cycle. Timer=0 releases EXE on that cycle and the state returns to RUN.
//   Latency 1 never stalls.
//  Load-use: EXE_MemRead & EXE_Dst!=0 & ((rsrtRead[1]&EXE_Dst==ID_rs)|(rsrtRead[0]&EXE_Dst==ID_rt)).
//   Response: PC_Wr=ID_Wr=0, EXE_Flush=1, MEM/WB proceed. Lasts exactly one cycle, because the load leaves EXE.
//  Branch taken (no higher event): ID_Flush=1 (kills the wrong-path IF instr). Delay slot in ID advances normally.
//   Branch+load-use together is impossible (same EXE slot); if seen, load-use wins.
//  Idle: all *_Wr=1, all flushes=0.
// CONFIGURATION
//  PERF_CNT_EN defined: adds out ports Perf_LdUse, Perf_MDU, Perf_Cache (32b each).
//   Each counts cycles in which that cause is the winning stall. Reset to 0, wrap at 2**32.
//  PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  CPU_Defines.svh: enum CtrlState_t {RUN,MDU,EXC_PEND}; struct PipeCtrlType {Wr,Flush} per stage.
//  Sub-module mdu_latency_timer: load/decrement/cancel counter, CNT_W wide, outputs busy/done.
// TESTING
//  1 Load in EXE (Dst=5), ID rs=5, rsrtRead=2'b10 -> one cycle PC_Wr=ID_Wr=0, EXE_Flush=1; next cycle all Wr=1.
//  2 DIV start in RUN, DIV_LAT=33 -> 32 cycles of ID/EXE_Wr=0, MEM_Flush=1; release on the 33rd cycle.
//  3 DIV running, MEM_ExcValid at timer=10 -> MDU_Cancel=1, flushes=1, PC_SelExc=1; next cycle RUN with timer=0.
//  4 MEM_ExcValid with I_Stall high 4 cycles -> EXC_PEND, PC_Wr=0 for 4 cycles, then a single PC_SelExc pulse.
//  5 EXE_BranchTaken alone -> ID_Flush=1, ID_Wr=1, EXE_Wr=1. With D_Stall=1 -> all Wr=0, no flush.
//  6 resetn dropped mid-DIV -> outputs at reset values immediately; after release state=RUN, no stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall sequencer: FSM states, the
// winning-cause decode and per-stage write/flush control pairs.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MDU,
      ST_EXC_PEND
   } ctrl_state_t;

   // Highest-priority event in the current cycle; drives both outputs and next state.
   typedef enum logic [2:0] {
      CAUSE_NONE,
      CAUSE_EXC,
      CAUSE_CACHE,
      CAUSE_MDU,
      CAUSE_LDUSE,
      CAUSE_BRANCH
   } stall_cause_t;

   typedef struct packed {
      logic wr;
      logic flush;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t STAGE_ADVANCE = '{wr: 1'b1, flush: 1'b0};
   localparam pipe_ctrl_t STAGE_HOLD    = '{wr: 1'b0, flush: 1'b0};
   localparam pipe_ctrl_t STAGE_BUBBLE  = '{wr: 1'b1, flush: 1'b1};
   localparam pipe_ctrl_t STAGE_KILL    = '{wr: 1'b0, flush: 1'b1};

   function automatic logic load_use_hit(
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic [1:0] rsrt_read,
      input logic [4:0] dst,
      input logic       mem_read
   );
      return mem_read && (dst != 5'd0) &&
             ((rsrt_read[1] && (dst == rs)) || (rsrt_read[0] && (dst == rt)));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_timer.sv
// mdu_latency_timer: remaining-occupancy counter for a multicycle MUL/DIV in EXE.
// busy = an operation is in flight; done = this is its last EXE cycle.
module mdu_latency_timer #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             cancel,
   output logic             busy,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (cancel) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign busy = (cnt != '0);
   assign done = (cnt <= CNT_W'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall/flush sequencer for the 5-stage pipe.
// Optional build macro PERF_CNT_EN adds Perf_LdUse/Perf_MDU/Perf_Cache counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned DIV_LAT = 33,
   parameter int unsigned CNT_W   = 6
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic [1:0]  ID_rsrtRead,
   input  logic [4:0]  EXE_Dst,
   input  logic        EXE_MemRead,
   input  logic        EXE_MulDivStart,
   input  logic        EXE_IsDiv,
   input  logic        EXE_BranchTaken,
   input  logic        I_Stall,
   input  logic        D_Stall,
   input  logic        MEM_ExcValid,
   output logic        PC_Wr,
   output logic        PC_SelExc,
   output logic        ID_Wr,
   output logic        ID_Flush,
   output logic        EXE_Wr,
   output logic        EXE_Flush,
   output logic        MEM_Wr,
   output logic        MEM_Flush,
   output logic        WB_Wr,
   output logic        MDU_Cancel
`ifdef PERF_CNT_EN
   ,
   output logic [31:0] Perf_LdUse,
   output logic [31:0] Perf_MDU,
   output logic [31:0] Perf_Cache
`endif
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

   ctrl_state_t      state;
   ctrl_state_t      state_nxt;
   stall_cause_t     cause;
   pipe_ctrl_t       id_c;
   pipe_ctrl_t       exe_c;
   pipe_ctrl_t       mem_c;
   logic             stall_any;
   logic             exc_active;
   logic             ld_use;
   logic             mdu_start;
   logic             mdu_hold;
   logic             tmr_load;
   logic             tmr_cancel;
   logic             tmr_busy;
   logic             tmr_done;
   logic [CNT_W-1:0] load_val;

   assign stall_any  = I_Stall | D_Stall;
   assign exc_active = MEM_ExcValid | (state == ST_EXC_PEND);
   assign load_val   = EXE_IsDiv ? DIV_LOAD : MUL_LOAD;
   assign ld_use     = load_use_hit(ID_rs, ID_rt, ID_rsrtRead, EXE_Dst, EXE_MemRead);
   assign mdu_start  = (state == ST_RUN) && EXE_MulDivStart && (load_val != '0);
   // A freeze may run the timer down to 0 while still in ST_MDU; !busy then releases too.
   assign mdu_hold   = (state == ST_MDU) && tmr_busy && !tmr_done;

   always_comb begin
      cause = CAUSE_NONE;
      if (exc_active) begin
         cause = CAUSE_EXC;
      end else if (stall_any) begin
         cause = CAUSE_CACHE;
      end else if (mdu_hold || mdu_start) begin
         cause = CAUSE_MDU;
      end else if (ld_use) begin
         cause = CAUSE_LDUSE;
      end else if (EXE_BranchTaken) begin
         cause = CAUSE_BRANCH;
      end
   end

   mdu_latency_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .resetn   (resetn),
      .load     (tmr_load),
      .load_val (load_val),
      .cancel   (tmr_cancel),
      .busy     (tmr_busy),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      tmr_load   = 1'b0;
      tmr_cancel = MEM_ExcValid;
      case (cause)
         CAUSE_EXC:   state_nxt = stall_any ? ST_EXC_PEND : ST_RUN;
         CAUSE_CACHE: state_nxt = state;
         CAUSE_MDU: begin
            state_nxt = ST_MDU;
            tmr_load  = (state == ST_RUN);
         end
         default:     state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      PC_Wr      = 1'b1;
      PC_SelExc  = 1'b0;
      id_c       = STAGE_ADVANCE;
      exe_c      = STAGE_ADVANCE;
      mem_c      = STAGE_ADVANCE;
      WB_Wr      = 1'b1;
      MDU_Cancel = 1'b0;
      if (!resetn) begin
         PC_Wr = 1'b0;
         id_c  = STAGE_KILL;
         exe_c = STAGE_KILL;
         mem_c = STAGE_KILL;
         WB_Wr = 1'b0;
      end else begin
         case (cause)
            CAUSE_EXC: begin
               PC_Wr      = !stall_any;
               PC_SelExc  = !stall_any;
               id_c       = STAGE_KILL;
               exe_c      = STAGE_KILL;
               mem_c      = STAGE_KILL;
               WB_Wr      = 1'b0;
               MDU_Cancel = MEM_ExcValid;
            end
            CAUSE_CACHE: begin
               PC_Wr = 1'b0;
               id_c  = STAGE_HOLD;
               exe_c = STAGE_HOLD;
               mem_c = STAGE_HOLD;
               WB_Wr = 1'b0;
            end
            CAUSE_MDU: begin
               PC_Wr = 1'b0;
               id_c  = STAGE_HOLD;
               exe_c = STAGE_HOLD;
               mem_c = STAGE_BUBBLE;
            end
            CAUSE_LDUSE: begin
               PC_Wr = 1'b0;
               id_c  = STAGE_HOLD;
               exe_c = STAGE_BUBBLE;
            end
            CAUSE_BRANCH: id_c = STAGE_BUBBLE;
            default: ;
         endcase
      end
   end

   assign ID_Wr     = id_c.wr;
   assign ID_Flush  = id_c.flush;
   assign EXE_Wr    = exe_c.wr;
   assign EXE_Flush = exe_c.flush;
   assign MEM_Wr    = mem_c.wr;
   assign MEM_Flush = mem_c.flush;

`ifdef PERF_CNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         Perf_LdUse <= '0;
         Perf_MDU   <= '0;
         Perf_Cache <= '0;
      end else begin
         if (cause == CAUSE_LDUSE) Perf_LdUse <= Perf_LdUse + 32'd1;
         if (cause == CAUSE_MDU)   Perf_MDU   <= Perf_MDU + 32'd1;
         if (cause == CAUSE_CACHE) Perf_Cache <= Perf_Cache + 32'd1;
      end
   end
`endif

endmodule
